fifo_read_gray_ctrl: RTL and testbench
======================================

# fifo_read_gray_ctrl

Read-side pointer and output controller of the `fifo_cdcc` asynchronous FIFO, paired with the write-side Gray controller across the clock-domain crossing. It synchronizes the write-domain Gray pointer into `rd_clk`, detects empty, and issues BRAM read enables and addresses. It drives an AXI-stream-style valid/ready output with a 2-entry output buffer for full throughput under back-pressure, and returns its registered Gray read pointer to the write domain.

## Interface
- `INT_FIFO_PTR_BITS_CNT`, default 32: address bits; depth = 2^N; minimum 2.
- `DATA_WIDTH`, default 32: BRAM/output word width.
- `rd_clk`  in  1  read-domain clock.
- `rd_rst_n`  in  1  reset; one clock, reset asynchronous active-low.
- `read_en`  out  1  BRAM read enable; data returned on `i_rd_data` exactly 1 cycle later.
- `o_rd_intptr`  out  N  BRAM read address (low N bits of the binary read pointer).
- `o_rd_grayptr`  out  N+1  registered Gray read pointer, to the write-domain synchronizer.
- `i_wr_grayptr`  in  N+1  raw Gray write pointer from the write domain (unsynchronized).
- `i_rd_data`  in  DATA_WIDTH  BRAM read data.
- `o_data`  out  DATA_WIDTH  output word.
- `o_valid`  out  1  output valid.
- `i_ready`  in  1  downstream ready.
- `o_fill_level`  out  N+1  occupancy estimate (only with macro, see Configuration).

## Operation
- `i_wr_grayptr` passes through a 2-FF synchronizer producing `wr_gray_s`.
- Binary read pointer `rd_ptr` (N+1 bits) wraps naturally mod 2^(N+1); `rd_gray = rd_ptr ^ (rd_ptr >> 1)` is held in a register updated with the next value, so `o_rd_grayptr` always equals the Gray of the current `rd_ptr`.
- Empty when all N+1 bits of `rd_gray == wr_gray_s`.
- Buffer occupancy `occ = out_v + skid_v + inflight` (0..2); `pop = o_valid & i_ready`.
- `read_en = ~empty & ((occ < 2) | pop)`; on `read_en`, `rd_ptr` increments and `inflight` sets for the next cycle.
- Landing (`inflight`): `i_rd_data` goes to the output register if it is empty or being popped with `skid_v = 0`, otherwise to the skid register.
- Pop: skid moves to the output register if `skid_v`, else `out_v` clears unless data is landing.
- `o_valid = out_v`. `o_data` is stable while `o_valid & ~i_ready`. Words exit strictly in FIFO order.
- Never reads when empty. Never overwrites an unpopped word. `occ` never exceeds 2.
- Wrap-around: address N-bit mod; MSB flip distinguishes full/empty on the write side only.

## Timing
- Reset (async assert, sync-released by the system): `rd_ptr = 0`, `o_rd_grayptr = 0`, `o_rd_intptr = 0`, `read_en = 0`, `o_valid = 0`, `o_data = 0`, skid/inflight cleared, synchronizer flops 0, `o_fill_level = 0`.
- Reset mid-operation: in-flight BRAM data is discarded and buffered words are lost; the FIFO is considered empty afterwards, and both sides must be reset together.
- Latency: `i_wr_grayptr` change → `wr_gray_s` after 2 `rd_clk` edges → `read_en` high in the following cycle → `o_valid` high after the 4th edge.
- Sustained throughput is 1 word/cycle while not empty and `i_ready = 1`.
- `i_ready` low: at most 2 further reads are issued, then `read_en` stays 0 until a pop.
- `read_en` is combinational from registers plus `i_ready`. All other outputs are registered.

## Configuration
- `FIFO_CDCC_FILL_LEVEL_EN` defined: port `o_fill_level` exists, registered each cycle as `gray2bin(wr_gray_s) - rd_ptr` (N+1 bits, mod 2^(N+1), range 0..2^N). Words held in the output buffer are not counted.
- Not defined: port and logic absent; behaviour is otherwise identical.

## Structure
- Shared package `fifo_cdcc_pkg`: `bin2gray` and `gray2bin` functions, pointer-width localparams, and reset value constants. It is also used by the write controller.
- Sub-module `fifo_gray_sync_2ff`, parameterized width N+1 with `rd_clk`/`rd_rst_n`, to be reused for the opposite crossing.

## Test plan
Bench uses N=4, DATA_WIDTH=8, and a BRAM model with 1-cycle latency.
- Reset with `i_wr_grayptr = 0`: `o_valid = 0`, `read_en = 0` for 20 cycles, `o_rd_grayptr = 0`.
- Step `i_wr_grayptr` 0→1 (one word 0xA5), `i_ready = 1`: `read_en` pulses once at cycle 3, `o_data = 0xA5` with `o_valid` at edge 4, `o_rd_grayptr = 1`, then empty.
- 16 words queued, `i_ready = 1`: 16 consecutive `read_en`. `o_rd_grayptr` ends at bin2gray(16) = 5'b11000. Outputs 0x00..0x0F in order with no bubbles.
- 8 words queued, `i_ready = 0` for 10 cycles: exactly 2 reads. `o_data` holds word 0 stable. Releasing `i_ready` drains all 8 in order with no loss or duplication.
- Pointer wrap: 40 words streamed with random `i_ready`: ordering intact across the `rd_ptr` 31→0 wrap.
- With `FIFO_CDCC_FILL_LEVEL_EN`, 6 words queued and 2 read: `o_fill_level = 4` once stable.

Source files
------------

// File: rtl/fifo_cdcc_pkg.sv
// Shared definitions for both sides of the fifo_cdcc asynchronous FIFO:
// Gray/binary conversion helpers, default widths and reset values.
package fifo_cdcc_pkg;

  localparam int PTR_WORD_BITS      = 64;
  localparam int DEFAULT_PTR_BITS   = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef logic [PTR_WORD_BITS-1:0] ptr_word_t;

  localparam ptr_word_t RST_PTR   = '0;
  localparam ptr_word_t RST_DATA  = '0;
  localparam logic      RST_VALID = 1'b0;

  // Callers zero-extend into ptr_word_t and size-cast the result back down,
  // so one function body serves every pointer width.
  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b = g;
    for (int i = 1; i < PTR_WORD_BITS; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer entering the rd_clk domain.
// Generic in width so the write side can reuse it for the opposite crossing.
module fifo_gray_sync_2ff
  import fifo_cdcc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_PTR_BITS + 1
) (
  input  logic             rd_clk,
  input  logic             rd_rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      meta_reg <= WIDTH'(RST_PTR);
      sync_reg <= WIDTH'(RST_PTR);
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/fifo_read_gray_ctrl.sv
// Read-side controller of fifo_cdcc: empty detection, BRAM read issue and a
// 2-entry valid/ready output buffer. FIFO_CDCC_FILL_LEVEL_EN adds o_fill_level.
module fifo_read_gray_ctrl
  import fifo_cdcc_pkg::*;
#(
  parameter int INT_FIFO_PTR_BITS_CNT = DEFAULT_PTR_BITS,
  parameter int DATA_WIDTH            = DEFAULT_DATA_WIDTH
) (
  input  logic                             rd_clk,
  input  logic                             rd_rst_n,
  output logic                             read_en,
  output logic [INT_FIFO_PTR_BITS_CNT-1:0] o_rd_intptr,
  output logic [INT_FIFO_PTR_BITS_CNT:0]   o_rd_grayptr,
  input  logic [INT_FIFO_PTR_BITS_CNT:0]   i_wr_grayptr,
  input  logic [DATA_WIDTH-1:0]            i_rd_data,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_valid,
  input  logic                             i_ready
`ifdef FIFO_CDCC_FILL_LEVEL_EN
  ,
  output logic [INT_FIFO_PTR_BITS_CNT:0]   o_fill_level
`endif
);

  localparam int PW = INT_FIFO_PTR_BITS_CNT + 1;

  logic [PW-1:0]         wr_gray_s;
  logic [PW-1:0]         rd_ptr_reg;
  logic [PW-1:0]         rd_ptr_next;
  logic [PW-1:0]         rd_gray_reg;
  logic [PW-1:0]         rd_gray_next;
  logic                  out_v_reg;
  logic                  skid_v_reg;
  logic                  inflight_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [DATA_WIDTH-1:0] skid_data_reg;
  logic                  empty;
  logic                  pop;
  logic [1:0]            occ;

  fifo_gray_sync_2ff #(
    .WIDTH (PW)
  ) u_wr_sync (
    .rd_clk   (rd_clk),
    .rd_rst_n (rd_rst_n),
    .d        (i_wr_grayptr),
    .q        (wr_gray_s)
  );

  assign empty = (rd_gray_reg == wr_gray_s);
  assign pop   = out_v_reg & i_ready;
  assign occ   = {1'b0, out_v_reg} + {1'b0, skid_v_reg} + {1'b0, inflight_reg};

  // A pop frees a slot in the same cycle, so a full buffer can still read.
  assign read_en = ~empty & ((occ < 2'd2) | pop);

  assign rd_ptr_next  = rd_ptr_reg + {{(PW-1){1'b0}}, read_en};
  assign rd_gray_next = PW'(bin2gray(ptr_word_t'(rd_ptr_next)));

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_ptr_reg    <= PW'(RST_PTR);
      rd_gray_reg   <= PW'(RST_PTR);
      inflight_reg  <= RST_VALID;
      out_v_reg     <= RST_VALID;
      skid_v_reg    <= RST_VALID;
      out_data_reg  <= DATA_WIDTH'(RST_DATA);
      skid_data_reg <= DATA_WIDTH'(RST_DATA);
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      rd_gray_reg  <= rd_gray_next;
      inflight_reg <= read_en;
      if (pop) begin
        if (skid_v_reg) begin
          out_data_reg <= skid_data_reg;
          if (inflight_reg) begin
            skid_data_reg <= i_rd_data;
          end else begin
            skid_v_reg <= 1'b0;
          end
        end else if (inflight_reg) begin
          out_data_reg <= i_rd_data;
        end else begin
          out_v_reg <= 1'b0;
        end
      end else if (inflight_reg) begin
        // Occupancy is capped at 2, so an occupied output implies an empty skid.
        if (!out_v_reg) begin
          out_data_reg <= i_rd_data;
          out_v_reg    <= 1'b1;
        end else begin
          skid_data_reg <= i_rd_data;
          skid_v_reg    <= 1'b1;
        end
      end
    end
  end

  assign o_rd_intptr  = rd_ptr_reg[INT_FIFO_PTR_BITS_CNT-1:0];
  assign o_rd_grayptr = rd_gray_reg;
  assign o_data       = out_data_reg;
  assign o_valid      = out_v_reg;

`ifdef FIFO_CDCC_FILL_LEVEL_EN
  logic [PW-1:0] fill_reg;

  // Counts words still in BRAM; words already in the output buffer are excluded.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      fill_reg <= PW'(RST_PTR);
    end else begin
      fill_reg <= PW'(gray2bin(ptr_word_t'(wr_gray_s))) - rd_ptr_reg;
    end
  end

  assign o_fill_level = fill_reg;
`endif

endmodule

// File: tb/tb_fifo_read_gray_ctrl.sv
// Randomized/directed bench for fifo_read_gray_ctrl with a 1-cycle BRAM model
// and a transaction-level model of issue, occupancy and FIFO ordering.
module tb_fifo_read_gray_ctrl;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n = 1'b0;
  logic          read_en;
  logic [N-1:0]  o_rd_intptr;
  logic [N:0]    o_rd_grayptr;
  logic [N:0]    i_wr_grayptr = '0;
  logic [DW-1:0] i_rd_data = '0;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          i_ready = 1'b0;
`ifdef FIFO_CDCC_FILL_LEVEL_EN
  logic [N:0]    o_fill_level;
`endif

  fifo_read_gray_ctrl #(
    .INT_FIFO_PTR_BITS_CNT (N),
    .DATA_WIDTH            (DW)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .read_en      (read_en),
    .o_rd_intptr  (o_rd_intptr),
    .o_rd_grayptr (o_rd_grayptr),
    .i_wr_grayptr (i_wr_grayptr),
    .i_rd_data    (i_rd_data),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready)
`ifdef FIFO_CDCC_FILL_LEVEL_EN
    ,
    .o_fill_level (o_fill_level)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge rd_clk) begin
    if (read_en) i_rd_data <= mem[o_rd_intptr];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_total = 0, wr_d1 = 0, wr_d2 = 0;
  int reads_total = 0, reads_prev = 0, pops_total = 0;
  int re_cnt = 0, re_first = -1, re_last = -1;
  int v_cnt = 0, v_first = -1, v_last = -1;
  logic [DW-1:0] sb [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N:0] gray5(input int v);
    logic [N:0] b;
    b = (N+1)'(v % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  // Negedge monitor: expectations come from word counts, not DUT state.
  always @(negedge rd_clk) begin : mon
    logic pop;
    int   occ;
    logic exp_re;
    if (rd_rst_n) begin
      chk("valid", o_valid, 64'(reads_prev > pops_total));
      if (o_valid) begin
        if (sb.size() == 0) chk("data_unexpected", 1, 0);
        else chk("data_order", o_data, sb[0]);
      end
      pop    = o_valid & i_ready;
      occ    = reads_total - pops_total;
      exp_re = (wr_d2 > reads_total) && ((occ < 2) || pop);
      chk("read_en", read_en, exp_re);
      chk("grayptr", o_rd_grayptr, gray5(reads_total));
      chk("intptr", o_rd_intptr, 64'(reads_total % DEPTH));
      if (pop) begin
        $display("xfer %0d data=%02h cyc=%0d", pops_total, o_data, cyc);
        if (sb.size() != 0) void'(sb.pop_front());
        pops_total++;
      end
      if (read_en) begin
        if (re_cnt == 0) re_first = cyc;
        re_last = cyc;
        re_cnt++;
      end
      if (o_valid) begin
        if (v_cnt == 0) v_first = cyc;
        v_last = cyc;
        v_cnt++;
      end
      reads_prev = reads_total;
      if (read_en) reads_total++;
      wr_d2 = wr_d1;
      wr_d1 = wr_total;
      cyc++;
    end
  end

  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic clr_stats();
    re_cnt = 0; re_first = -1; re_last = -1;
    v_cnt = 0;  v_first = -1;  v_last = -1;
  endtask

  task automatic put(input logic [DW-1:0] d);
    mem[wr_total % DEPTH] = d;
    sb.push_back(d);
    wr_total++;
    i_wr_grayptr = gray5(wr_total);
  endtask

  task automatic do_reset();
    rd_rst_n = 1'b0;
    i_ready = 1'b0;
    i_wr_grayptr = '0;
    wr_total = 0; wr_d1 = 0; wr_d2 = 0;
    reads_total = 0; reads_prev = 0; pops_total = 0;
    sb.delete();
    clr_stats();
    repeat (3) step();
    chk("rst_valid", o_valid, 0);
    chk("rst_read_en", read_en, 0);
    chk("rst_gray", o_rd_grayptr, 0);
    chk("rst_intptr", o_rd_intptr, 0);
    chk("rst_data", o_data, 0);
    rd_rst_n = 1'b1;
  endtask

  initial begin : main
    int c0;
    int sent;

    // Idle after reset
    do_reset();
    repeat (20) step();
    chk("idle_re_cnt", re_cnt, 0);
    chk("idle_v_cnt", v_cnt, 0);
    chk("idle_gray", o_rd_grayptr, 0);

    // Single word latency
    clr_stats();
    i_ready = 1'b1;
    c0 = cyc;
    put(8'hA5);
    repeat (8) step();
    chk("one_re_cnt", re_cnt, 1);
    chk("one_re_cycle", re_first, c0 + 2);
    chk("one_v_cycle", v_first, c0 + 4);
    chk("one_v_cnt", v_cnt, 1);
    chk("one_gray", o_rd_grayptr, 1);
    chk("one_pops", pops_total, 1);

    // Full-depth burst, no bubbles
    do_reset();
    i_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) put(DW'(i));
    repeat (30) step();
    chk("burst_re_cnt", re_cnt, 16);
    chk("burst_re_run", re_last - re_first, 15);
    chk("burst_v_cnt", v_cnt, 16);
    chk("burst_v_run", v_last - v_first, 15);
    chk("burst_gray", o_rd_grayptr, 64'(5'b11000));
    chk("burst_pops", pops_total, 16);

    // Back-pressure
    do_reset();
    for (int i = 0; i < 8; i++) put(8'h30 + DW'(i));
    repeat (10) step();
    chk("bp_re_cnt", re_cnt, 2);
    chk("bp_valid", o_valid, 1);
    chk("bp_data", o_data, 8'h30);
    i_ready = 1'b1;
    repeat (20) step();
    chk("bp_pops", pops_total, 8);
    chk("bp_re_total", re_cnt, 8);
    chk("bp_sb_empty", sb.size(), 0);

    // Random stream across the pointer wrap
    do_reset();
    sent = 0;
    for (int k = 0; k < 3000 && pops_total < 40; k++) begin
      step();
      i_ready = 1'($urandom_range(0, 1));
      if (sent < 40 && $urandom_range(0, 2) != 0 && (wr_total - reads_total) < DEPTH) begin
        put(DW'($urandom));
        sent++;
      end
    end
    chk("wrap_pops", pops_total, 40);
    chk("wrap_gray", o_rd_grayptr, gray5(40));
    chk("wrap_sb_empty", sb.size(), 0);

`ifdef FIFO_CDCC_FILL_LEVEL_EN
    do_reset();
    for (int i = 0; i < 6; i++) put(8'h60 + DW'(i));
    repeat (10) step();
    chk("fill_re_cnt", re_cnt, 2);
    chk("fill_level", o_fill_level, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
